// File: rtl/rot_pkg.sv
// Shared types for the sequential rotate controller: FSM states and direction codes.
package rot_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rot1_step.sv
// Single-bit rotate stage; passes data through when not enabled.
module rot1_step
    import rot_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_in,
    input  logic             ena,
    input  logic             dir,
    output logic [WIDTH-1:0] data_out
);

    // Select pass-through, rotate right or rotate left by one bit
    always_comb begin
        data_out = data_in;
        if (!ena) begin
            data_out = data_in;
        end else if (dir == DIR_RIGHT) begin
            data_out = {data_in[0], data_in[WIDTH-1:1]};
        end else begin
            data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
        end
    end

endmodule

// File: rtl/rot_seq_ctrl.sv
// Sequential rotate controller: applies one 1-bit rotate per clock until the
// requested amount is reached, with valid/ready handshakes on both sides.
module rot_seq_ctrl
    import rot_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = $clog2(WIDTH),
    parameter bit SHORT_PATH = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_steps,
    output logic             busy
);

    localparam logic [CNT_W-1:0] HALF_AMT = CNT_W'(WIDTH / 2);

    state_t           state_r;
    logic [WIDTH-1:0] data_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] steps_r;
    logic             dir_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             busy_r;
    logic             eff_dir_s;
    logic [CNT_W-1:0] eff_cnt_s;
    logic [WIDTH-1:0] rot_s;

    // Long rotations take the opposite direction; 0 - amt wraps to WIDTH - amt
    always_comb begin
        eff_dir_s = in_dir;
        eff_cnt_s = in_amt;
        if (SHORT_PATH && (in_amt > HALF_AMT)) begin
            eff_dir_s = ~in_dir;
            eff_cnt_s = {CNT_W{1'b0}} - in_amt;
        end else begin
            eff_dir_s = in_dir;
            eff_cnt_s = in_amt;
        end
    end

    rot1_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_in  (data_r),
        .ena      (state_r == RUN),
        .dir      (dir_r),
        .data_out (rot_s)
    );

    // Controller FSM with registered handshake and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            data_r      <= {WIDTH{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            steps_r     <= {CNT_W{1'b0}};
            dir_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        data_r     <= in_data;
                        dir_r      <= eff_dir_s;
                        cnt_r      <= eff_cnt_s;
                        steps_r    <= eff_cnt_s;
                        in_ready_r <= 1'b0;
                        if (eff_cnt_s == {CNT_W{1'b0}}) begin
                            state_r     <= DONE;
                            out_valid_r <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    data_r <= rot_s;
                    cnt_r  <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        state_r     <= DONE;
                        busy_r      <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r & rst_n;
    assign out_valid = out_valid_r;
    assign out_data  = data_r;
    assign out_steps = steps_r;
    assign busy      = busy_r;

endmodule
